// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: single-cycle ALU results compete with a small
// FIFO of long-latency results; a starvation counter forces the FIFO head through.
module writeback_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid_i,
  input  logic [4:0]                    alu_rd_addr_i,
  input  logic [31:0]                   alu_data_i,
  input  logic                          lsu_valid_i,
  output logic                          lsu_ready_o,
  input  logic [4:0]                    lsu_rd_addr_i,
  input  logic [31:0]                   lsu_data_i,
  output logic                          alu_stall_o,
  output logic [4:0]                    rd_addr_o,
  output logic [31:0]                   write_data_o,
  output logic                          reg_write_en_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic [36:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [SW-1:0] starve_reg, starve_next;
  logic          stall_reg, stall_next;
  logic [4:0]    rd_addr_reg;
  logic [31:0]   write_data_reg;
  logic          write_en_reg;

  logic nonempty, alu_win, pop, lsu_accept, push;

  // Decisions use only registered occupancy, so a push is never poppable in the same cycle.
  always_comb begin
    nonempty    = (count_reg != '0);
    alu_win     = !stall_reg && alu_valid_i && (alu_rd_addr_i != 5'd0);
    pop         = nonempty && !alu_win;
    lsu_ready_o = (count_reg < DEPTH_C);
    lsu_accept  = lsu_valid_i && lsu_ready_o;
    push        = lsu_accept && (lsu_rd_addr_i != 5'd0);
    count_next  = count_reg + CW'(push) - CW'(pop);
    starve_next = starve_reg;
    stall_next  = 1'b0;
    if (pop || !nonempty) begin
      starve_next = '0;
    end else if (alu_win && starve_reg != LIMIT_C) begin
      starve_next = starve_reg + SW'(1);
      stall_next  = (starve_next == LIMIT_C);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr_reg] <= {lsu_rd_addr_i, lsu_data_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      starve_reg     <= '0;
      stall_reg      <= 1'b0;
      rd_addr_reg    <= 5'd0;
      write_data_reg <= 32'd0;
      write_en_reg   <= 1'b0;
    end else begin
      count_reg    <= count_next;
      starve_reg   <= starve_next;
      stall_reg    <= stall_next;
      write_en_reg <= alu_win || pop;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (alu_win) begin
        rd_addr_reg    <= alu_rd_addr_i;
        write_data_reg <= alu_data_i;
      end else if (pop) begin
        rd_addr_reg    <= mem[rd_ptr_reg][36:32];
        write_data_reg <= mem[rd_ptr_reg][31:0];
        rd_ptr_reg     <= rd_ptr_reg + PW'(1);
      end
    end
  end

  assign alu_stall_o    = stall_reg;
  assign rd_addr_o      = rd_addr_reg;
  assign write_data_o   = write_data_reg;
  assign reg_write_en_o = write_en_reg;
  assign fifo_count_o   = count_reg;

endmodule
